// File: rtl/data_sram_responder.sv
// Data-side SRAM responder for a single-cycle core: word RAM plus a small
// memory-mapped register window (LED, switches, timer, scratch, store counter).
module data_sram_responder #(
    parameter int          RAM_AW    = 10,
    parameter logic [31:0] CONF_BASE = 32'hbfaf_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led
);

    // Register selects are word offsets, i.e. byte offset [15:2]
    localparam logic [13:0] SEL_LED     = 14'd0;
    localparam logic [13:0] SEL_SWITCH  = 14'd1;
    localparam logic [13:0] SEL_TIMER   = 14'd2;
    localparam logic [13:0] SEL_SCRATCH = 14'd3;
    localparam logic [13:0] SEL_WR_CNT  = 14'd4;

    logic [31:0]       r_ram [2**RAM_AW];
    logic [15:0]       r_led;
    logic [7:0]        r_sw_meta;
    logic [7:0]        r_sw_sync;
    logic [31:0]       r_timer;
    logic [31:0]       r_scratch;
    logic [31:0]       r_wr_cnt;

    logic              w_conf_hit;
    logic [13:0]       w_reg_sel;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_reg_we;
    logic              w_ram_we;
    logic              w_unused_addr;

    assign w_conf_hit    = (data_sram_addr[31:16] == CONF_BASE[31:16]);
    assign w_reg_sel     = data_sram_addr[15:2];
    assign w_ram_idx     = data_sram_addr[RAM_AW+1:2];
    assign w_reg_we      = data_sram_we & w_conf_hit;
    assign w_ram_we      = resetn & data_sram_we & ~w_conf_hit;
    assign w_unused_addr = &{1'b0, data_sram_addr[1:0]};

    assign led = r_led;

    // RAM contents survive reset, so the array sits outside the reset domain
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= data_sram_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_led     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_timer   <= '0;
            r_scratch <= '0;
            r_wr_cnt  <= '0;
        end else begin
            r_sw_meta <= switch;
            r_sw_sync <= r_sw_meta;
            // A store to TIMER wins over the free-running increment
            if (w_reg_we && w_reg_sel == SEL_TIMER) begin
                r_timer <= data_sram_wdata;
            end else begin
                r_timer <= r_timer + 32'd1;
            end
            if (w_reg_we && w_reg_sel == SEL_LED) begin
                r_led <= data_sram_wdata[15:0];
            end
            if (w_reg_we && w_reg_sel == SEL_SCRATCH) begin
                r_scratch <= data_sram_wdata;
            end
            if (data_sram_we) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        data_sram_rdata = '0;
        if (w_conf_hit) begin
            case (w_reg_sel)
                SEL_LED:     data_sram_rdata = {16'b0, r_led};
                SEL_SWITCH:  data_sram_rdata = {24'b0, r_sw_sync};
                SEL_TIMER:   data_sram_rdata = r_timer;
                SEL_SCRATCH: data_sram_rdata = r_scratch;
                SEL_WR_CNT:  data_sram_rdata = r_wr_cnt;
                default:     data_sram_rdata = '0;
            endcase
        end else begin
            data_sram_rdata = r_ram[w_ram_idx];
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed test-plan steps plus a random phase,
// all compared against an abstract model of the memory map.
module tb_data_sram_responder;

    localparam logic [31:0] BASE = 32'hbfaf_0000;

    logic        clk;
    logic        resetn;
    logic        data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch;
    logic [15:0] led;

    int n_err = 0;
    int n_checks = 0;

    // Abstract model: RAM as a sparse word map, registers as plain variables
    logic [31:0] m_mem [int];
    logic [15:0] m_led;
    logic [31:0] m_timer, m_scratch, m_wrcnt;
    logic [7:0]  m_sw1, m_sw2;

    data_sram_responder #(.RAM_AW(10), .CONF_BASE(BASE)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch          (switch),
        .led             (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_led = '0; m_timer = '0; m_scratch = '0; m_wrcnt = '0;
        m_sw1 = '0; m_sw2 = '0;
    endtask

    function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
        v = '0;
        if (a[31:16] == BASE[31:16]) begin
            case ({a[15:2], 2'b00})
                16'h0000: v = {16'b0, m_led};
                16'h0004: v = {24'b0, m_sw2};
                16'h0008: v = m_timer;
                16'h000C: v = m_scratch;
                16'h0010: v = m_wrcnt;
                default:  v = '0;
            endcase
            return 1'b1;
        end
        if (m_mem.exists(int'(a[11:2]))) begin
            v = m_mem[int'(a[11:2])];
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic loaded;
        loaded = 1'b0;
        m_sw2 = m_sw1;
        m_sw1 = switch;
        if (we) begin
            m_wrcnt = m_wrcnt + 32'd1;
            if (a[31:16] == BASE[31:16]) begin
                case ({a[15:2], 2'b00})
                    16'h0000: m_led = d[15:0];
                    16'h0008: begin m_timer = d; loaded = 1'b1; end
                    16'h000C: m_scratch = d;
                    default: ;
                endcase
            end else begin
                m_mem[int'(a[11:2])] = d;
            end
        end
        if (!loaded) m_timer = m_timer + 32'd1;
    endtask

    // One full cycle: drive, check combinational read and LED, clock, update model
    task automatic drive_check(input logic we, input logic [31:0] a, input logic [31:0] d,
                               input string tag);
        logic [31:0] exp;
        bit known;
        data_sram_we = we; data_sram_addr = a; data_sram_wdata = d;
        #2;
        known = model_read(a, exp);
        if (known) check(tag, data_sram_rdata, exp);
        check({tag, "_led"}, {16'b0, led}, {16'b0, m_led});
        @(posedge clk);
        model_edge(we, a, d);
        #1;
    endtask

    task automatic peek(input logic [31:0] a, input string tag, input logic [31:0] exp);
        data_sram_we = 1'b0; data_sram_addr = a;
        #1;
        check(tag, data_sram_rdata, exp);
    endtask

    initial begin
        logic [31:0] a;
        int idx;
        resetn = 1'b1; data_sram_we = 1'b0; data_sram_addr = '0;
        data_sram_wdata = '0; switch = 8'h00;
        model_reset();
        #1 resetn = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_led", {16'b0, led}, 32'h0);
        peek(BASE + 32'h8, "rst_timer_in_reset", 32'h0);
        resetn = 1'b1;
        peek(BASE + 32'h8, "timer_before_edge", 32'h0);
        for (int i = 0; i < 5; i++) drive_check(1'b0, BASE + 32'h8, 32'h0, "timer_idle");
        peek(BASE + 32'h8, "timer_after5", 32'd5);
        peek(BASE + 32'h10, "wrcnt_idle", 32'd0);

        // RAM store/load and aliasing
        drive_check(1'b1, 32'h0000_0010, 32'h1111_2222, "ram_init");
        drive_check(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "ram_old_same_cycle");
        peek(32'h0000_0010, "ram_new", 32'hDEAD_BEEF);
        peek(32'h0000_1010, "ram_alias", 32'hDEAD_BEEF);

        // LED, scratch, read-only switch
        drive_check(1'b1, BASE, 32'h1234_A5A5, "led_wr");
        check("led_pin", {16'b0, led}, 32'h0000_A5A5);
        peek(BASE, "led_rd", 32'h0000_A5A5);
        drive_check(1'b1, BASE + 32'hC, 32'hCAFE_F00D, "scratch_wr");
        peek(BASE + 32'hC, "scratch_rd", 32'hCAFE_F00D);
        drive_check(1'b1, BASE + 32'h4, 32'hFFFF_FFFF, "switch_wr");
        peek(BASE + 32'h4, "switch_ro", 32'h0);

        // Timer load and wrap
        drive_check(1'b1, BASE + 32'h8, 32'hFFFF_FFFE, "timer_load");
        peek(BASE + 32'h8, "timer_fffe", 32'hFFFF_FFFE);
        drive_check(1'b0, BASE + 32'h8, 32'h0, "timer_run");
        peek(BASE + 32'h8, "timer_ffff", 32'hFFFF_FFFF);
        drive_check(1'b0, BASE + 32'h8, 32'h0, "timer_run");
        peek(BASE + 32'h8, "timer_wrap", 32'h0);

        // Store counting from a fresh reset
        resetn = 1'b0; model_reset();
        @(posedge clk); #1;
        resetn = 1'b1;
        drive_check(1'b1, 32'h0000_0100, 32'hA000_0001, "cnt_ram0");
        drive_check(1'b1, 32'h0000_0104, 32'hA000_0002, "cnt_ram1");
        drive_check(1'b1, 32'h0000_0108, 32'hA000_0003, "cnt_ram2");
        drive_check(1'b1, BASE + 32'h20, 32'h5555_5555, "cnt_unmapped0");
        drive_check(1'b1, BASE + 32'h20, 32'h6666_6666, "cnt_unmapped1");
        drive_check(1'b1, BASE + 32'h10, 32'h7777_7777, "cnt_self0");
        drive_check(1'b1, BASE + 32'h10, 32'h8888_8888, "cnt_self1");
        peek(BASE + 32'h10, "wrcnt_7", 32'd7);
        peek(BASE + 32'h20, "unmapped_rd", 32'h0);

        // Switch synchroniser
        switch = 8'h5A;
        drive_check(1'b0, BASE + 32'h4, 32'h0, "sw_edge1");
        peek(BASE + 32'h4, "sw_after1", 32'h0);
        drive_check(1'b0, BASE + 32'h4, 32'h0, "sw_edge2");
        peek(BASE + 32'h4, "sw_after2", 32'h0000_005A);

        // Random traffic; RAM limited to word indices 32..63 with aliased upper bits
        for (int i = 0; i < 300; i++) begin
            switch = 8'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                idx = $urandom_range(32, 63);
                a = ($urandom & 32'h7FFF_F000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            end else begin
                a = BASE | (32'($urandom_range(0, 9)) << 2) | 32'($urandom_range(0, 3));
            end
            drive_check(1'($urandom_range(0, 1)), a, $urandom, "rand");
        end

        // Asynchronous reset in mid-cycle with a SCRATCH store pending
        switch = 8'h00;
        data_sram_we = 1'b1; data_sram_addr = BASE + 32'hC; data_sram_wdata = 32'h5555_AAAA;
        #2;
        resetn = 1'b0; model_reset();
        #1;
        check("scratch_in_reset", data_sram_rdata, 32'h0);
        @(posedge clk); #1;
        check("scratch_store_lost", data_sram_rdata, 32'h0);
        peek(BASE + 32'h10, "wrcnt_store_lost", 32'h0);
        resetn = 1'b1;
        peek(BASE + 32'h8, "timer_release", 32'h0);
        drive_check(1'b0, BASE + 32'hC, 32'h0, "scratch_after_rel");
        peek(BASE + 32'h8, "timer_release_1", 32'd1);
        peek(32'h0000_0010, "ram_kept_10", 32'hDEAD_BEEF);
        peek(32'h0000_0104, "ram_kept_104", 32'hA000_0002);
        foreach (m_mem[k]) drive_check(1'b0, 32'(k) << 2, 32'h0, "ram_kept");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
